// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the external 16-bit SRAM controller: state encoding and defaults.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_ADDR_W      = 18;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int DEF_BASE_ADDR   = 1024;

  // Counter width that stays legal when a phase is a single cycle.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Per-phase cycle counter: flags the final cycle of a half-word phase and the write-strobe window.
module sram_phase_timer
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic last,
  output logic strobe_ok
);

  localparam int CW = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Wraps to zero on the last cycle so LO hands a fresh count to HI.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= '0;
    end else if (run) begin
      if (last) r_cnt <= '0;
      else      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign last = (r_cnt == LAST_CNT);

  // With multi-cycle phases the strobe releases one cycle early to give data hold time.
  generate
    if (WAIT_CYCLES == 1) begin : g_single
      assign strobe_ok = 1'b1;
    end else begin : g_multi
      assign strobe_ok = !last;
    end
  endgenerate

endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage to 16-bit async SRAM sequencer; each 32-bit access is two timed half-word phases.
// Define SRAM_CTRL_POSTED_WRITE_EN to let stores complete in the background without freezing.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int          ADDR_W      = DEF_ADDR_W,
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = 32'(DEF_BASE_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_we_n
);

`ifdef SRAM_CTRL_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  state_t            r_state;
  state_t            w_state_next;
  logic              r_is_store;
  logic [ADDR_W-2:0] r_word_idx;
  logic [31:0]       r_wdata;
  logic [31:0]       r_read_data;

  logic        w_req;
  logic        w_start;
  logic        w_run;
  logic        w_hi;
  logic        w_last;
  logic        w_strobe_ok;
  logic        w_ready_base;
  logic [31:0] w_offset;
  logic        w_unused_offset;

  assign w_req    = rd_en | wr_en;
  assign w_start  = (r_state == ST_IDLE) && w_req;
  assign w_hi     = (r_state == ST_HI);
  assign w_run    = (r_state == ST_LO) || w_hi;
  assign w_offset = address - BASE_ADDR;
  assign w_unused_offset = &{1'b0, w_offset[31:ADDR_W+1], w_offset[1:0]};

  sram_phase_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (w_start),
    .run       (w_run),
    .last      (w_last),
    .strobe_ok (w_strobe_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_state_next = ST_LO;
      ST_LO:   if (w_last) w_state_next = ST_HI;
      ST_HI:   if (w_last) w_state_next = (POSTED && r_is_store) ? ST_IDLE : ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A simultaneous rd_en/wr_en is a store because wr_en alone decides the op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_store <= 1'b0;
      r_word_idx <= '0;
      r_wdata    <= '0;
    end else if (w_start) begin
      r_is_store <= wr_en;
      r_word_idx <= w_offset[ADDR_W:2];
      r_wdata    <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_data <= '0;
    end else if (w_run && w_last && !r_is_store) begin
      if (w_hi) r_read_data[31:16] <= sram_dq_in;
      else      r_read_data[15:0]  <= sram_dq_in;
    end
  end

  assign read_data = r_read_data;

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (w_run) begin
      sram_addr = {r_word_idx, w_hi};
      if (r_is_store) begin
        sram_dq_out = w_hi ? r_wdata[31:16] : r_wdata[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = !w_strobe_ok;
      end
    end
  end

  assign w_ready_base = ((r_state == ST_IDLE) && !w_req) || (r_state == ST_DONE);

`ifdef SRAM_CTRL_POSTED_WRITE_EN
  // A posted store releases the pipeline at once; a follow-up request stalls until IDLE.
  assign ready = w_ready_base
               || ((r_state == ST_IDLE) && wr_en)
               || (w_run && r_is_store && !w_req);
`else
  assign ready = w_ready_base;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: per-cycle bus expectations and load results queued at drive time.
module tb_sram_ctrl;

  localparam int          AW = 18;
  localparam int          WC = 2;
  localparam logic [31:0] BA = 32'd1024;

  logic          clk;
  logic          rst;
  logic          rd_en;
  logic          wr_en;
  logic [31:0]   address;
  logic [31:0]   write_data;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic [15:0]   sram_dq_in;
  logic          sram_dq_oe;
  logic          sram_we_n;

  sram_ctrl #(
    .ADDR_W      (AW),
    .WAIT_CYCLES (WC),
    .BASE_ADDR   (BA)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small SRAM model: asynchronous read, write sampled while the strobe is low.
  logic [15:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] <= 16'h0;
  assign sram_dq_in = mem[sram_addr[9:0]];
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr[9:0]] <= sram_dq_out;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   dq;
    logic          oe;
    logic          we_n;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] rd_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_rd = 32'h0;

  function automatic logic [AW-1:0] exp_addr(input logic [31:0] a, input logic ph);
    logic [31:0] idx;
    idx = (a - BA) >> 2;
    return {idx[AW-2:0], ph};
  endfunction

  task automatic run_access(input bit st, input bit both, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_rd, input string name);
    bus_t        e;
    bit          posted;
    int          last_c;
    logic        exp_ready;
    logic [31:0] exp_val;
    posted = 1'b0;
`ifdef SRAM_CTRL_POSTED_WRITE_EN
    posted = st;
`endif
    last_c = posted ? 2 * WC : 2 * WC + 1;
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < WC; k++) begin
        e.addr = exp_addr(a, ph[0]);
        e.dq   = st ? ((ph == 1) ? d[31:16] : d[15:0]) : 16'h0;
        e.oe   = st;
        e.we_n = st ? ((WC >= 2 && k == WC - 1) ? 1'b1 : 1'b0) : 1'b1;
        bus_q.push_back(e);
      end
    end
    if (!st) rd_q.push_back(exp_rd);
    rd_en      = !st || both;
    wr_en      = st;
    address    = a;
    write_data = d;
    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk);
      exp_ready = posted ? 1'b1 : (c == last_c);
      total++;
      if (ready !== exp_ready) begin
        bad++;
        $display("FAIL %s ready cyc%0d: got %b want %b", name, c, ready, exp_ready);
      end
      if (c >= 1 && c <= 2 * WC) begin
        e = bus_q.pop_front();
        total++;
        if ({sram_addr, sram_dq_out, sram_dq_oe, sram_we_n} !== e) begin
          bad++;
          $display("FAIL %s bus cyc%0d: got addr=%h dq=%h oe=%b we_n=%b want addr=%h dq=%h oe=%b we_n=%b",
                   name, c, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, e.addr, e.dq, e.oe, e.we_n);
        end
      end
      if (c == last_c && !posted) begin
        if (!st) begin
          exp_val = rd_q.pop_front();
          last_rd = exp_val;
        end
        total++;
        if (read_data !== last_rd) begin
          bad++;
          $display("FAIL %s read_data: got %h want %h", name, read_data, last_rd);
        end
      end
      @(posedge clk);
      #1;
      if (posted && c == 0) begin
        rd_en = 1'b0;
        wr_en = 1'b0;
      end
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    $display("txn %s %s addr=%0d wdata=%h read_data=%h", name, st ? "store" : "load", a, d, read_data);
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'h0; write_data = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total += 6;
    if (ready !== 1'b1)        begin bad++; $display("FAIL reset ready: got %b want 1", ready); end
    if (sram_we_n !== 1'b1)    begin bad++; $display("FAIL reset we_n: got %b want 1", sram_we_n); end
    if (sram_dq_oe !== 1'b0)   begin bad++; $display("FAIL reset oe: got %b want 0", sram_dq_oe); end
    if (read_data !== 32'h0)   begin bad++; $display("FAIL reset read_data: got %h want 0", read_data); end
    if (sram_addr !== '0)      begin bad++; $display("FAIL reset sram_addr: got %h want 0", sram_addr); end
    if (sram_dq_out !== 16'h0) begin bad++; $display("FAIL reset dq_out: got %h want 0", sram_dq_out); end
    $display("txn reset idle ready=%b we_n=%b oe=%b", ready, sram_we_n, sram_dq_oe);
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    run_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 32'h0, "store1028");
    @(negedge clk);
    total += 2;
    if (mem[2] !== 16'hBEEF) begin bad++; $display("FAIL store lo word: got %h want beef", mem[2]); end
    if (mem[3] !== 16'hDEAD) begin bad++; $display("FAIL store hi word: got %h want dead", mem[3]); end
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    run_access(1'b0, 1'b0, 32'd1028, 32'h0, 32'hDEADBEEF, "load1028");
  endtask

  task automatic test_both();
    run_access(1'b1, 1'b1, 32'd1024, 32'h12345678, 32'h0, "both1024");
    run_access(1'b0, 1'b0, 32'd1024, 32'h0, 32'h12345678, "load1024");
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 32'd1032, 32'h0BADF00D, 32'h0, "b2b_store");
    run_access(1'b0, 1'b0, 32'd1032, 32'h0, 32'h0BADF00D, "b2b_load");
    run_access(1'b0, 1'b0, 32'd1028, 32'h0, 32'hDEADBEEF, "b2b_load2");
  endtask

  task automatic test_reset_abort();
    rd_en = 1'b0; wr_en = 1'b1; address = 32'd2000; write_data = 32'hA5A55A5A;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; wr_en = 1'b0;
    last_rd = 32'h0;
    @(negedge clk);
    total += 5;
    if (sram_we_n !== 1'b1)  begin bad++; $display("FAIL abort we_n: got %b want 1", sram_we_n); end
    if (sram_dq_oe !== 1'b0) begin bad++; $display("FAIL abort oe: got %b want 0", sram_dq_oe); end
    if (ready !== 1'b1)      begin bad++; $display("FAIL abort ready: got %b want 1", ready); end
    if (read_data !== 32'h0) begin bad++; $display("FAIL abort read_data: got %h want 0", read_data); end
    if (mem[488] !== 16'h5A5A) begin bad++; $display("FAIL abort lo half: got %h want 5a5a", mem[488]); end
    $display("txn abort store addr=2000 we_n=%b oe=%b", sram_we_n, sram_dq_oe);
    @(posedge clk); #1;
    run_access(1'b0, 1'b0, 32'd1032, 32'h0, 32'h0BADF00D, "after_abort");
  endtask

`ifdef SRAM_CTRL_POSTED_WRITE_EN
  task automatic test_posted();
    logic exp_ready;
    rd_en = 1'b0; wr_en = 1'b1; address = 32'd1100; write_data = 32'hCAFEF00D;
    for (int c = 0; c <= 2 * WC + 2 * WC + 2; c++) begin
      @(negedge clk);
      exp_ready = (c == 0) || (c == 4 * WC + 2);
      total++;
      if (ready !== exp_ready) begin
        bad++;
        $display("FAIL posted ready cyc%0d: got %b want %b", c, ready, exp_ready);
      end
      if (c == 4 * WC + 2) begin
        total++;
        if (read_data !== 32'hCAFEF00D) begin
          bad++;
          $display("FAIL posted read_data: got %h want cafef00d", read_data);
        end
        last_rd = 32'hCAFEF00D;
      end
      @(posedge clk);
      #1;
      if (c == 0) begin
        rd_en = 1'b1; wr_en = 1'b0; address = 32'd1100; write_data = 32'h0;
      end
    end
    rd_en = 1'b0; wr_en = 1'b0;
    $display("txn posted store+load addr=1100 read_data=%h", read_data);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store();
    test_load();
    test_both();
    test_back_to_back();
    test_reset_abort();
`ifdef SRAM_CTRL_POSTED_WRITE_EN
    test_posted();
`endif
    total++;
    if (bus_q.size() != 0 || rd_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard drain: got bus=%0d rd=%0d want 0", bus_q.size(), rd_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
